// File: rtl/smoosh_pkg.sv
// Shared types and constants for the NES pad emulator.
package smoosh_pkg;

  localparam int unsigned PAD_BITS = 8;

  // Button positions within the 8-bit button word / serial frame.
  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } pad_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall detection
// against a registered previous value.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the pin through the synchroniser chain and remember the last level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/nes_pad_emulator.sv
// Device-side NES controller responder: behaves like the 4021 shift register
// inside a pad, driven by an asynchronous host latch and controller clock.
module nes_pad_emulator
  import smoosh_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000,
  parameter logic        EMPTY_LEVEL    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                latch_in,
  input  logic                ctrl_clk_in,
  input  logic [PAD_BITS-1:0] buttons,
  output logic                data_out,
  output logic                busy,
  output logic                frame_done,
  output logic [3:0]          shift_count
);

  logic latch_lvl, latch_rise, latch_fall;
  logic ctrl_lvl_unused, ctrl_rise, ctrl_fall;
  logic any_edge;

  pad_state_t          state_q, state_d;
  logic [PAD_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]          count_q, count_d;
  logic [23:0]         tmo_q, tmo_d;
  logic                data_q, data_d;
  logic                done_q, done_d;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk      (clk),
    .rst      (rst),
    .async_in (latch_in),
    .level    (latch_lvl),
    .rise     (latch_rise),
    .fall     (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ctrl (
    .clk      (clk),
    .rst      (rst),
    .async_in (ctrl_clk_in),
    .level    (ctrl_lvl_unused),
    .rise     (ctrl_rise),
    .fall     (ctrl_fall)
  );

  assign any_edge = latch_rise | latch_fall | ctrl_rise | ctrl_fall;

  // State register plus shift register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '1;
      count_q <= '0;
      tmo_q   <= '0;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; latch rise outranks a coincident clock rise, and the
  // idle timeout only fires when no edge arrived this cycle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    tmo_d   = '0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (latch_lvl) begin
          state_d = LOAD;
          shreg_d = ~buttons;
          count_d = '0;
        end
      end
      LOAD: begin
        count_d = '0;
        if (latch_fall) begin
          state_d = SHIFT;
        end else begin
          shreg_d = ~buttons;
        end
      end
      SHIFT, DONE: begin
        if (latch_rise) begin
          state_d = LOAD;
          shreg_d = ~buttons;
          count_d = '0;
        end else if (ctrl_rise && state_q == SHIFT) begin
          shreg_d = {EMPTY_LEVEL, shreg_q[PAD_BITS-1:1]};
          count_d = count_q + 4'd1;
          if (count_q == 4'd7) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (!any_edge && tmo_q >= TIMEOUT_CYCLES - 24'd1) begin
          state_d = IDLE;
          shreg_d = '1;
          count_d = '0;
        end else if (!any_edge) begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial output follows the current state/shift register one cycle later.
  always_comb begin
    data_d = 1'b1;
    unique case (state_q)
      IDLE:        data_d = 1'b1;
      LOAD, SHIFT: data_d = shreg_q[0];
      DONE:        data_d = EMPTY_LEVEL;
      default:     data_d = 1'b1;
    endcase
  end

  assign data_out    = data_q;
  assign busy        = (state_q == LOAD) || (state_q == SHIFT);
  assign frame_done  = done_q;
  assign shift_count = count_q;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Self-checking bench for nes_pad_emulator: host-side protocol stimulus with
// randomized buttons and pulse counts, checked against a frame-level model.
module tb_nes_pad_emulator;

  localparam int unsigned TMO = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       latch_in;
  logic       ctrl_clk_in;
  logic [7:0] buttons;
  logic       data_out;
  logic       busy;
  logic       frame_done;
  logic [3:0] shift_count;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned fd_seen = 0;
  int unsigned fd_base = 0;

  // Frame-level model: button word captured at latch fall and bits consumed.
  logic [7:0]  cur_btn;
  int unsigned nshift;

  nes_pad_emulator #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (24'(TMO)),
    .EMPTY_LEVEL    (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .latch_in    (latch_in),
    .ctrl_clk_in (ctrl_clk_in),
    .buttons     (buttons),
    .data_out    (data_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .shift_count (shift_count)
  );

  always #5 clk = ~clk;

  // Count frame_done cycles, sampled away from the active edge.
  always @(negedge clk) if (frame_done === 1'b1) fd_seen++;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit the host should see after k clock pulses (pad is active-low).
  function automatic logic exp_data(input logic [7:0] b, input int unsigned k);
    logic [2:0] idx;
    idx = k[2:0];
    return (k < 8) ? ~b[idx] : 1'b0;
  endfunction

  task automatic do_latch(input logic [7:0] first_b, input logic [7:0] final_b);
    buttons  = first_b;
    latch_in = 1'b1;
    wait_cyc(4);
    buttons = final_b;
    wait_cyc(5);
    check_eq("busy_load", 8'(busy), 8'd1);
    check_eq("cnt_load", 8'(shift_count), 8'd0);
    latch_in = 1'b0;
    wait_cyc(6);
    cur_btn = final_b;
    nshift  = 0;
    fd_base = fd_seen;
    check_eq("bit_a", 8'(data_out), 8'(exp_data(cur_btn, 0)));
    check_eq("cnt_after_latch", 8'(shift_count), 8'd0);
  endtask

  task automatic do_pulse();
    ctrl_clk_in = 1'b1;
    wait_cyc(3 + $urandom_range(0, 2));
    ctrl_clk_in = 1'b0;
    wait_cyc(6);
    nshift = (nshift < 8) ? nshift + 1 : 8;
    check_eq($sformatf("bit%0d", nshift), 8'(data_out), 8'(exp_data(cur_btn, nshift)));
    check_eq($sformatf("cnt%0d", nshift), 8'(shift_count), 8'(nshift));
    check_eq($sformatf("busy%0d", nshift), 8'(busy), (nshift < 8) ? 8'd1 : 8'd0);
  endtask

  task automatic frame_end_check(input string tag);
    check_eq(tag, 8'(fd_seen - fd_base), (nshift >= 8) ? 8'd1 : 8'd0);
  endtask

  initial begin
    logic [7:0] nb;
    int unsigned n;

    rst = 1'b1; latch_in = 1'b0; ctrl_clk_in = 1'b0; buttons = 8'h00;
    wait_cyc(3);
    check_eq("rst_data", 8'(data_out), 8'd1);
    check_eq("rst_busy", 8'(busy), 8'd0);
    check_eq("rst_fd", 8'(frame_done), 8'd0);
    check_eq("rst_cnt", 8'(shift_count), 8'd0);
    rst = 1'b0;
    wait_cyc(3);
    check_eq("idle_data", 8'(data_out), 8'd1);

    // No buttons pressed: all ones, then the empty level.
    do_latch(8'h00, 8'h00);
    for (int i = 0; i < 8; i++) do_pulse();
    frame_end_check("fd_frame0");

    // A, Select, Right.
    do_latch(8'h85, 8'h85);
    for (int i = 0; i < 8; i++) do_pulse();
    frame_end_check("fd_frame85");

    // Last value loaded before latch fall is used.
    do_latch(8'h01, 8'h02);
    do_pulse();
    frame_end_check("fd_lastload");

    // Abort after 3 bits with a new latch.
    do_latch(8'($urandom), 8'h3C);
    for (int i = 0; i < 3; i++) do_pulse();
    frame_end_check("fd_abort");
    do_latch(8'hFF, 8'hFF);
    check_eq("abort_data", 8'(data_out), 8'd0);
    for (int i = 0; i < 8; i++) do_pulse();
    frame_end_check("fd_after_abort");

    // Latch rise and clock rise on the same cycle: latch wins.
    do_latch(8'h5A, 8'h5A);
    for (int i = 0; i < 2; i++) do_pulse();
    frame_end_check("fd_pre_same");
    nb = 8'($urandom) | 8'h01;
    buttons = nb; latch_in = 1'b1; ctrl_clk_in = 1'b1;
    wait_cyc(7);
    check_eq("same_cnt", 8'(shift_count), 8'd0);
    check_eq("same_busy", 8'(busy), 8'd1);
    ctrl_clk_in = 1'b0;
    wait_cyc(4);
    latch_in = 1'b0;
    wait_cyc(6);
    cur_btn = nb; nshift = 0; fd_base = fd_seen;
    check_eq("same_bit_a", 8'(data_out), 8'(exp_data(cur_btn, 0)));
    check_eq("same_cnt2", 8'(shift_count), 8'd0);
    for (int i = 0; i < 8; i++) do_pulse();
    frame_end_check("fd_same");

    // Timeout mid-SHIFT.
    do_latch(8'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) do_pulse();
    wait_cyc(50);
    check_eq("tmo_early_busy", 8'(busy), 8'd1);
    check_eq("tmo_early_cnt", 8'(shift_count), 8'd3);
    wait_cyc(80);
    check_eq("tmo_busy", 8'(busy), 8'd0);
    check_eq("tmo_data", 8'(data_out), 8'd1);
    check_eq("tmo_cnt", 8'(shift_count), 8'd0);
    frame_end_check("fd_tmo");

    // Random frames: random buttons, button churn during shift, 0..10 pulses.
    for (int f = 0; f < 24; f++) begin
      do_latch(8'($urandom), 8'($urandom));
      buttons = 8'($urandom);
      n = $urandom_range(0, 10);
      for (int unsigned p = 0; p < n; p++) do_pulse();
      frame_end_check($sformatf("fd_rand%0d", f));
    end

    // Reset mid-frame.
    do_latch(8'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) do_pulse();
    rst = 1'b1;
    wait_cyc(1);
    check_eq("mrst_data", 8'(data_out), 8'd1);
    check_eq("mrst_busy", 8'(busy), 8'd0);
    check_eq("mrst_fd", 8'(frame_done), 8'd0);
    check_eq("mrst_cnt", 8'(shift_count), 8'd0);
    rst = 1'b0;
    wait_cyc(3);
    check_eq("mrst_idle_busy", 8'(busy), 8'd0);
    check_eq("mrst_idle_data", 8'(data_out), 8'd1);
    do_latch(8'h00, 8'hA7);
    for (int i = 0; i < 8; i++) do_pulse();
    frame_end_check("fd_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
